branch_target_predictor: RTL and testbench

//  Parametrised direct-mapped branch predictor: a table of N-bit saturating counters plus a tagged

---
 rtl/branch_target_predictor_pkg.sv | 33 +++
 rtl/branch_target_predictor_sat.sv | 22 ++
 rtl/branch_target_predictor.sv | 105 ++++++++++
 tb/tb_branch_target_predictor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: the CPU word type, index/tag width helpers,
// and the default-sized BTB entry layout.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

package bpred_pkg;
   import cpu_types_pkg::*;

   localparam int unsigned BP_ENTRIES = 16;
   localparam int unsigned BP_CTR_W   = 2;

   function automatic int unsigned idx_w(input int unsigned entries);
      return $clog2(entries);
   endfunction

   // The tag covers pc[31:IDX_W+2], leaving out the index and the two byte-offset bits.
   function automatic int unsigned tag_w(input int unsigned entries);
      return 30 - $clog2(entries);
   endfunction

   localparam int unsigned IDX_W = idx_w(BP_ENTRIES);
   localparam int unsigned TAG_W = tag_w(BP_ENTRIES);

   typedef logic [BP_CTR_W-1:0] ctr_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      word_t            target;
      ctr_t             ctr;
   } btb_entry_t;
endpackage

// File: rtl/branch_target_predictor_sat.sv
// Saturating up/down counter next-value logic; o_msb is the taken prediction for the
// current value.
module sat_counter #(
   parameter int unsigned CTR_W = 2
) (
   input  logic [CTR_W-1:0] i_ctr,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CTR_W-1:0] o_next,
   output logic             o_msb
);
   always_comb begin
      o_next = i_ctr;
      if (i_inc && !i_dec) begin
         if (i_ctr != '1) o_next = i_ctr + CTR_W'(1);
      end else if (i_dec && !i_inc) begin
         if (i_ctr != '0) o_next = i_ctr - CTR_W'(1);
      end
   end

   assign o_msb = i_ctr[CTR_W-1];
endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch predictor: per-PC saturating counters plus a tagged target buffer.
// Fetch looks up combinationally; the resolve stage writes outcomes back on the clock edge.
module branch_target_predictor
   import cpu_types_pkg::*;
   import bpred_pkg::*;
#(
   parameter int unsigned ENTRIES  = BP_ENTRIES,
   parameter int unsigned CTR_W    = BP_CTR_W,
   parameter int unsigned CTR_INIT = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        flush,
   output logic [15:0] mispredict_cnt
);
   localparam int unsigned L_IDX_W = idx_w(ENTRIES);
   localparam int unsigned L_TAG_W = tag_w(ENTRIES);
   localparam logic [CTR_W-1:0] L_CTR_INIT = CTR_W'(CTR_INIT);
   localparam logic [CTR_W-1:0] L_CTR_RST  = CTR_W'(CTR_INIT - 1);

   // Same layout as btb_entry_t, re-declared so ENTRIES/CTR_W overrides resize it.
   typedef struct packed {
      logic               valid;
      logic [L_TAG_W-1:0] tag;
      word_t              target;
      logic [CTR_W-1:0]   ctr;
   } entry_t;

   entry_t             r_tbl [ENTRIES];
   logic [15:0]        r_mispredict_cnt;

   logic [L_IDX_W-1:0] w_lk_idx;
   logic [L_TAG_W-1:0] w_lk_tag;
   logic [L_IDX_W-1:0] w_up_idx;
   logic [L_TAG_W-1:0] w_up_tag;
   entry_t             w_up_ent;
   logic               w_up_hit;
   logic               w_up_msb;
   logic               w_mispredict;
   logic [CTR_W-1:0]   w_ctr_next;
   logic               w_unused_pc_lsb;

   assign w_lk_idx = lookup_pc[L_IDX_W+1:2];
   assign w_lk_tag = lookup_pc[31:L_IDX_W+2];
   assign w_up_idx = update_pc[L_IDX_W+1:2];
   assign w_up_tag = update_pc[31:L_IDX_W+2];
   assign w_unused_pc_lsb = ^{lookup_pc[1:0], update_pc[1:0]};

   assign pred_hit       = r_tbl[w_lk_idx].valid && (r_tbl[w_lk_idx].tag == w_lk_tag);
   assign pred_taken     = pred_hit && r_tbl[w_lk_idx].ctr[CTR_W-1];
   assign pred_target    = pred_hit ? r_tbl[w_lk_idx].target : '0;
   assign mispredict_cnt = r_mispredict_cnt;

   assign w_up_ent = r_tbl[w_up_idx];
   assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

   sat_counter #(
      .CTR_W (CTR_W)
   ) u_sat (
      .i_ctr  (w_up_ent.ctr),
      .i_inc  (update_taken),
      .i_dec  (!update_taken),
      .o_next (w_ctr_next),
      .o_msb  (w_up_msb)
   );

   assign w_mispredict = ((w_up_hit ? w_up_msb : 1'b0) != update_taken) ||
                         (w_up_hit && update_taken && (w_up_ent.target != update_target));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_tbl[i].valid  <= 1'b0;
            r_tbl[i].tag    <= '0;
            r_tbl[i].target <= '0;
            r_tbl[i].ctr    <= L_CTR_RST;
         end
         r_mispredict_cnt <= '0;
      end else if (flush) begin
         // Only valid bits clear; the concurrent update is dropped and not counted.
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_tbl[i].valid <= 1'b0;
         end
      end else if (update_en) begin
         if (w_up_hit) begin
            r_tbl[w_up_idx].ctr <= w_ctr_next;
            if (update_taken) r_tbl[w_up_idx].target <= update_target;
         end else if (update_taken) begin
            r_tbl[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: update_target,
                                 ctr: L_CTR_INIT};
         end
         if (w_mispredict && (r_mispredict_cnt != 16'hFFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed scoreboard bench for branch_target_predictor (ENTRIES=16, CTR_W=2, CTR_INIT=2).
module tb_branch_target_predictor;
   logic        clk;
   logic        n_rst;
   logic [31:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        flush;
   logic [15:0] mispredict_cnt;

   branch_target_predictor #(
      .ENTRIES  (16),
      .CTR_W    (2),
      .CTR_INIT (2)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .lookup_pc      (lookup_pc),
      .pred_hit       (pred_hit),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .update_en      (update_en),
      .update_pc      (update_pc),
      .update_taken   (update_taken),
      .update_target  (update_target),
      .flush          (flush),
      .mispredict_cnt (mispredict_cnt)
   );

   typedef struct {
      string       tag;
      int unsigned kind;
      logic [31:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Push expectations for a lookup, let the combinational outputs settle, then drain.
   task automatic probe(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt, input logic [15:0] cnt);
      sb_t e;
      lookup_pc = pc;
      sb_q.push_back('{tag: {tag, ".hit"},    kind: 0, exp: {31'b0, hit}});
      sb_q.push_back('{tag: {tag, ".taken"},  kind: 1, exp: {31'b0, taken}});
      sb_q.push_back('{tag: {tag, ".target"}, kind: 2, exp: tgt});
      sb_q.push_back('{tag: {tag, ".cnt"},    kind: 3, exp: {16'b0, cnt}});
      #1;
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            0:       chk(e.tag, {31'b0, pred_hit}, e.exp);
            1:       chk(e.tag, {31'b0, pred_taken}, e.exp);
            2:       chk(e.tag, pred_target, e.exp);
            default: chk(e.tag, {16'b0, mispredict_cnt}, e.exp);
         endcase
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      update_en     = 1'b1;
      update_pc     = pc;
      update_taken  = taken;
      update_target = tgt;
      @(posedge clk);
      #1;
      update_en = 1'b0;
   endtask

   initial begin
      n_rst = 1'b0; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
      update_taken = 1'b0; update_target = '0; flush = 1'b0;
      #2;
      probe("reset", 32'h40, 1'b0, 1'b0, 32'h0, 16'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Allocation on a taken miss: weakly taken, counted as a misprediction.
      upd(32'h40, 1'b1, 32'h100);
      probe("alloc", 32'h40, 1'b1, 1'b1, 32'h100, 16'd1);

      // 10 -> 01 -> 00, then hold at 00.
      upd(32'h40, 1'b0, 32'h0);
      probe("nt1", 32'h40, 1'b1, 1'b0, 32'h100, 16'd2);
      upd(32'h40, 1'b0, 32'h0);
      upd(32'h40, 1'b0, 32'h0);
      probe("nt3", 32'h40, 1'b1, 1'b0, 32'h100, 16'd2);
      upd(32'h40, 1'b1, 32'h100);
      probe("t1_from00", 32'h40, 1'b1, 1'b0, 32'h100, 16'd3);
      upd(32'h40, 1'b1, 32'h100);
      upd(32'h40, 1'b1, 32'h100);
      upd(32'h40, 1'b1, 32'h100);
      probe("t4_sat11", 32'h40, 1'b1, 1'b1, 32'h100, 16'd4);
      upd(32'h40, 1'b0, 32'h0);
      probe("nt_from11", 32'h40, 1'b1, 1'b1, 32'h100, 16'd5);

      // Alias at index 0: 0x80 evicts 0x40.
      upd(32'h80, 1'b1, 32'h200);
      probe("alias_old", 32'h40, 1'b0, 1'b0, 32'h0, 16'd6);
      probe("alias_new", 32'h80, 1'b1, 1'b1, 32'h200, 16'd6);

      // Re-allocate 0x40, drop it to 01, then update+lookup in the same cycle.
      upd(32'h40, 1'b1, 32'h100);
      upd(32'h40, 1'b0, 32'h0);
      update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h100;
      probe("bypass_pre", 32'h40, 1'b1, 1'b0, 32'h100, 16'd8);
      @(posedge clk);
      #1;
      update_en = 1'b0;
      probe("bypass_post", 32'h43, 1'b1, 1'b1, 32'h100, 16'd9);

      // Flush beats a simultaneous mispredicting update.
      flush = 1'b1;
      update_en = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h300;
      @(posedge clk);
      #1;
      flush = 1'b0; update_en = 1'b0;
      probe("flush_40", 32'h40, 1'b0, 1'b0, 32'h0, 16'd9);
      probe("flush_80", 32'h80, 1'b0, 1'b0, 32'h0, 16'd9);

      // A not-taken miss allocates nothing.
      upd(32'h40, 1'b0, 32'h0);
      probe("nt_miss", 32'h40, 1'b0, 1'b0, 32'h0, 16'd9);

      // Every update below mispredicts (alloc, then a new target each cycle).
      update_en = 1'b1; update_pc = 32'hC4; update_taken = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         update_target = 32'h1000 + 32'(i) * 32'd4;
         @(posedge clk);
         #1;
      end
      probe("cnt_sat", 32'hC4, 1'b1, 1'b1, 32'h1000 + 32'd69999 * 32'd4, 16'hFFFF);

      // Asynchronous reset in the middle of an update stream.
      update_target = 32'hDEAD_0000;
      #1;
      n_rst = 1'b0;
      probe("async_rst", 32'hC4, 1'b0, 1'b0, 32'h0, 16'd0);
      @(posedge clk);
      #1;
      probe("rst_held", 32'hC4, 1'b0, 1'b0, 32'h0, 16'd0);
      update_en = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      probe("post_rst", 32'h40, 1'b0, 1'b0, 32'h0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
